// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: accepts one memory op from execute,
// issues a single data-cache request, aligns/extends the load response and
// emits a one-cycle writeback pulse. One access outstanding, flushable.
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned
// half/word/double accesses with a one-cycle misalign pulse.
module lsu_mem_ctrl #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned LREG_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [3:0]        ls_size,
    input  logic              is_unsigned,
    input  logic [XLEN-1:0]   ls_address,
    input  logic [XLEN-1:0]   store_data,
    input  logic [LREG_W-1:0] rd,
    input  logic              flush,
    output logic              dc_req_valid,
    input  logic              dc_req_ready,
    output logic [XLEN-1:0]   dc_req_addr,
    output logic              dc_req_wen,
    output logic [XLEN-1:0]   dc_req_wdata,
    output logic [7:0]        dc_req_wmask,
    input  logic              dc_resp_valid,
    input  logic [XLEN-1:0]   dc_resp_data,
    output logic              wb_valid,
    output logic [LREG_W-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              misalign
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [7:0]          wmask_q, wmask_d;
    logic                wen_q, wen_d;
    logic [3:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [LREG_W-1:0]   rd_q, rd_d;
    logic                wb_valid_q, wb_valid_d;
    logic [LREG_W-1:0]   wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]     wb_data_q, wb_data_d;
    logic                misalign_q, misalign_d;

    logic                accept;
    logic                op_valid;
    logic                mis_hit;
    logic [7:0]          base_mask;
    logic [XLEN-1:0]     lane;
    logic [XLEN-1:0]     load_ext;

    assign in_ready = (state_q == S_IDLE) && !flush && !reset;
    assign accept   = in_valid && in_ready;
    assign op_valid = is_load || is_store;

`ifdef LSU_MISALIGN_CHECK_EN
    assign mis_hit = (ls_size[1] && ls_address[0])
                  || (ls_size[2] && (ls_address[1:0] != 2'b00))
                  || (ls_size[3] && (ls_address[2:0] != 3'b000));
`else
    assign mis_hit = 1'b0;
`endif

    // Byte-enable pattern for the incoming access size, before lane shift.
    always_comb begin
        base_mask = '0;
        if (ls_size[3])      base_mask = 8'hFF;
        else if (ls_size[2]) base_mask = 8'h0F;
        else if (ls_size[1]) base_mask = 8'h03;
        else if (ls_size[0]) base_mask = 8'h01;
    end

    // Move the addressed lane of the response down to bit 0 and extend it.
    always_comb begin
        lane     = dc_resp_data >> {addr_q[2:0], 3'b000};
        load_ext = '0;
        if (size_q[3])      load_ext = lane;
        else if (size_q[2]) load_ext = {{(XLEN-32){!uns_q && lane[31]}}, lane[31:0]};
        else if (size_q[1]) load_ext = {{(XLEN-16){!uns_q && lane[15]}}, lane[15:0]};
        else if (size_q[0]) load_ext = {{(XLEN-8){!uns_q && lane[7]}}, lane[7:0]};
    end

    // Next-state and registered-output computation for the access sequencer.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        wen_d      = wen_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        misalign_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && op_valid) begin
                    if (mis_hit) begin
                        misalign_d = 1'b1;
                    end else begin
                        addr_d  = ls_address;
                        wdata_d = store_data << {ls_address[2:0], 3'b000};
                        wmask_d = is_store ? (base_mask << ls_address[2:0]) : 8'h00;
                        wen_d   = is_store;
                        size_d  = ls_size;
                        uns_d   = is_unsigned;
                        rd_d    = rd;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dc_req_ready) begin
                    if (wen_q)      state_d = S_IDLE;
                    else if (flush) state_d = S_DRAIN;
                    else            state_d = S_WAIT;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                // A flush arriving together with the response consumes and
                // discards it; waiting in DRAIN would never see another one.
                if (dc_resp_valid) begin
                    state_d = S_IDLE;
                    if (!flush) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = load_ext;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (dc_resp_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state and latched request/result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            wen_q      <= 1'b0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            wen_q      <= wen_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
        end
    end

    assign dc_req_valid = (state_q == S_REQ);
    assign dc_req_addr  = {addr_q[XLEN-1:3], 3'b000};
    assign dc_req_wen   = wen_q;
    assign dc_req_wdata = wdata_q;
    assign dc_req_wmask = wmask_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign misalign     = misalign_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_lsu_mem_ctrl;

    localparam int XLEN   = 64;
    localparam int LREG_W = 5;
`ifdef LSU_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid, in_ready, is_load, is_store, is_unsigned, flush;
    logic [3:0]        ls_size;
    logic [XLEN-1:0]   ls_address, store_data;
    logic [LREG_W-1:0] rd;
    logic              dc_req_valid, dc_req_ready, dc_req_wen;
    logic [XLEN-1:0]   dc_req_addr, dc_req_wdata;
    logic [7:0]        dc_req_wmask;
    logic              dc_resp_valid;
    logic [XLEN-1:0]   dc_resp_data;
    logic              wb_valid, misalign;
    logic [LREG_W-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;

    always #5 clock = ~clock;

    lsu_mem_ctrl #(.XLEN(XLEN), .LREG_W(LREG_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .is_load(is_load), .is_store(is_store), .ls_size(ls_size),
        .is_unsigned(is_unsigned), .ls_address(ls_address),
        .store_data(store_data), .rd(rd), .flush(flush),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_addr(dc_req_addr), .dc_req_wen(dc_req_wen),
        .dc_req_wdata(dc_req_wdata), .dc_req_wmask(dc_req_wmask),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign(misalign)
    );

    int checks   = 0;
    int failures = 0;

    // Transaction-level model: is a request on the bus, is a load response
    // owed, and should that response be thrown away.
    bit                m_req, m_resp_due, m_discard;
    logic [XLEN-1:0]   m_addr, m_wdata, m_wb_data;
    logic [7:0]        m_wmask;
    bit                m_wen, m_uns, m_wb_valid, m_mis;
    int                m_nb;
    logic [LREG_W-1:0] m_rd, m_wb_rd;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [3:0] s);
        if (s[3]) return 8;
        if (s[2]) return 4;
        if (s[1]) return 2;
        if (s[0]) return 1;
        return 0;
    endfunction

    function automatic logic [63:0] extract(input logic [63:0] resp, input int off,
                                            input int nb, input bit uns);
        logic [63:0] v;
        logic [63:0] ones;
        v    = '0;
        ones = '1;
        for (int i = 0; i < nb; i++)
            if (off + i < 8) v = v | (64'(resp[8*(off+i) +: 8]) << (8*i));
        if (!uns && nb < 8 && nb > 0 && v[8*nb-1]) v = v | (ones << (8*nb));
        return v;
    endfunction

    function automatic logic [63:0] place_data(input logic [63:0] sd, input int off);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 8; i++)
            if (i >= off) v[8*i +: 8] = sd[8*(i-off) +: 8];
        return v;
    endfunction

    function automatic logic [7:0] place_mask(input int off, input int nb);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < nb; i++)
            if (off + i < 8) m[off+i] = 1'b1;
        return m;
    endfunction

    task automatic model_clear();
        m_req = 0; m_resp_due = 0; m_discard = 0;
        m_wb_valid = 0; m_mis = 0; m_wb_data = '0; m_wb_rd = '0;
    endtask

    task automatic model_step();
        bit nwb;
        bit nmis;
        int off;
        nwb  = 0;
        nmis = 0;
        off  = int'(ls_address[2:0]);
        if (!m_req && !m_resp_due) begin
            if (in_valid && !flush && (is_load || is_store)) begin
                if (MIS_EN && nbytes(ls_size) > 1 && (off % nbytes(ls_size)) != 0) begin
                    nmis = 1;
                end else begin
                    m_req   = 1;
                    m_addr  = ls_address;
                    m_wen   = is_store;
                    m_nb    = nbytes(ls_size);
                    m_uns   = is_unsigned;
                    m_rd    = rd;
                    m_wdata = place_data(store_data, off);
                    m_wmask = is_store ? place_mask(off, m_nb) : 8'h00;
                end
            end
        end else if (m_req) begin
            if (dc_req_ready) begin
                m_req = 0;
                if (!m_wen) begin
                    m_resp_due = 1;
                    m_discard  = flush;
                end
            end else if (flush) begin
                m_req = 0;
            end
        end else begin
            if (dc_resp_valid) begin
                m_resp_due = 0;
                if (!m_discard && !flush) begin
                    nwb       = 1;
                    m_wb_data = extract(dc_resp_data, int'(m_addr[2:0]), m_nb, m_uns);
                    m_wb_rd   = m_rd;
                end
            end else if (flush) begin
                m_discard = 1;
            end
        end
        m_wb_valid = nwb;
        m_mis      = nmis;
    endtask

    task automatic compare();
        chk("in_ready", in_ready, !reset && !m_req && !m_resp_due && !flush);
        chk("dc_req_valid", dc_req_valid, m_req);
        if (m_req) begin
            chk("dc_req_addr", dc_req_addr, m_addr & ~64'h7);
            chk("dc_req_wen", dc_req_wen, m_wen);
            chk("dc_req_wdata", dc_req_wdata, m_wdata);
            chk("dc_req_wmask", dc_req_wmask, m_wmask);
        end
        chk("wb_valid", wb_valid, m_wb_valid);
        chk("wb_rd", wb_rd, m_wb_rd);
        chk("wb_data", wb_data, m_wb_data);
        chk("misalign", misalign, m_mis);
    endtask

    // Inputs for the current cycle are already applied at posedge+1.
    task automatic tick();
        #1;
        if (reset) model_clear();
        compare();
        if (!reset) model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 0; is_load = 0; is_store = 0; flush = 0;
        dc_req_ready = 0; dc_resp_valid = 0;
    endtask

    task automatic set_op(input bit ld, input bit st, input logic [3:0] sz, input bit uns,
                          input logic [63:0] a, input logic [63:0] d, input logic [4:0] r);
        in_valid = 1; is_load = ld; is_store = st; ls_size = sz; is_unsigned = uns;
        ls_address = a; store_data = d; rd = r; flush = 0;
    endtask

    // Minimum-latency load with an always-ready cache; checks the result.
    task automatic load_simple(input string nm, input logic [3:0] sz, input bit uns,
                               input logic [63:0] a, input logic [63:0] resp,
                               input logic [63:0] exp);
        idle_in(); set_op(1, 0, sz, uns, a, 64'h0, 5'd7); dc_req_ready = 1; tick();
        idle_in(); dc_req_ready = 1; tick();
        idle_in(); dc_resp_valid = 1; dc_resp_data = resp; tick();
        idle_in();
        chk({nm, "_wb_valid"}, wb_valid, 1'b1);
        chk({nm, "_wb_data"}, wb_data, exp);
        tick();
    endtask

    initial begin
        idle_in();
        ls_size = 4'b0001; is_unsigned = 0; ls_address = '0; store_data = '0; rd = '0;
        dc_resp_data = '0;
        model_clear();
        reset = 1;
        @(posedge clock); #1;
        tick();
        reset = 0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_wb_data", wb_data, 64'h0);
        chk("rst_req_valid", dc_req_valid, 1'b0);

        // Doubleword load, minimum latency.
        idle_in(); set_op(1, 0, 4'b1000, 0, 64'h1000, 64'h0, 5'd3); dc_req_ready = 1; tick();
        idle_in(); dc_req_ready = 1;
        chk("ldd_req_valid", dc_req_valid, 1'b1);
        chk("ldd_addr", dc_req_addr, 64'h1000);
        chk("ldd_wmask", dc_req_wmask, 8'h00);
        tick();
        idle_in(); dc_resp_valid = 1; dc_resp_data = 64'h1122334455667788;
        chk("ldd_no_early_wb", wb_valid, 1'b0);
        tick();
        idle_in();
        chk("ldd_wb_valid", wb_valid, 1'b1);
        chk("ldd_wb_data", wb_data, 64'h1122334455667788);
        chk("ldd_wb_rd", wb_rd, 5'd3);
        tick();
        chk("ldd_pulse_end", wb_valid, 1'b0);
        chk("ldd_hold", wb_data, 64'h1122334455667788);

        // Byte loads, signed and unsigned.
        load_simple("ldb_s", 4'b0001, 0, 64'h1003, 64'h0000000080FF0000, 64'hFFFFFFFFFFFFFF80);
        load_simple("ldb_u", 4'b0001, 1, 64'h1003, 64'h0000000080FF0000, 64'h0000000000000080);

        // Halfword store with a stalled cache.
        idle_in(); set_op(0, 1, 4'b0010, 0, 64'h2006, 64'hABCD, 5'd0); tick();
        for (int k = 0; k < 4; k++) begin
            idle_in(); dc_req_ready = (k == 3);
            chk("sth_valid", dc_req_valid, 1'b1);
            chk("sth_wdata", dc_req_wdata, 64'hABCD000000000000);
            chk("sth_wmask", dc_req_wmask, 8'hC0);
            chk("sth_wen", dc_req_wen, 1'b1);
            tick();
        end
        idle_in(); #1;
        chk("sth_ready_back", in_ready, 1'b1);
        chk("sth_no_wb", wb_valid, 1'b0);
        tick();

        // Word load flushed while waiting for its response.
        idle_in(); set_op(1, 0, 4'b0100, 0, 64'h3000, 64'h0, 5'd9); dc_req_ready = 1; tick();
        idle_in(); dc_req_ready = 1; tick();
        idle_in(); flush = 1; tick();
        idle_in(); tick();
        idle_in(); dc_resp_valid = 1; dc_resp_data = 64'h5555AAAA5555AAAA; #1;
        chk("flw_busy", in_ready, 1'b0);
        tick();
        idle_in(); #1;
        chk("flw_ready_back", in_ready, 1'b1);
        chk("flw_no_wb", wb_valid, 1'b0);
        tick();

        // Flush while the request is stalled, then a normal load.
        idle_in(); set_op(1, 0, 4'b1000, 0, 64'h4000, 64'h0, 5'd1); tick();
        idle_in(); flush = 1; tick();
        idle_in(); #1;
        chk("flr_req_drop", dc_req_valid, 1'b0);
        chk("flr_ready", in_ready, 1'b1);
        load_simple("flr_next", 4'b0100, 1, 64'h4004, 64'hDEADBEEF01234567, 64'h00000000DEADBEEF);

        // Misaligned word load.
        idle_in(); set_op(1, 0, 4'b0100, 1, 64'h1002, 64'h0, 5'd4); dc_req_ready = 1; tick();
        idle_in(); dc_req_ready = 1;
        if (MIS_EN) begin
            chk("mis_pulse", misalign, 1'b1);
            chk("mis_no_req", dc_req_valid, 1'b0);
            tick();
            idle_in();
            chk("mis_pulse_end", misalign, 1'b0);
            tick();
        end else begin
            chk("mis_req_addr", dc_req_addr, 64'h1000);
            chk("mis_off", misalign, 1'b0);
            tick();
            idle_in(); dc_resp_valid = 1; dc_resp_data = 64'h0011223344556677; tick();
            idle_in();
            chk("mis_wb_data", wb_data, 64'h0000000022334455);
            tick();
        end

        // Randomized traffic checked every cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            reset        = ($urandom_range(0, 399) == 0);
            in_valid     = $urandom_range(0, 1);
            case ($urandom_range(0, 2))
                0:       begin is_load = 0; is_store = 0; end
                1:       begin is_load = 1; is_store = 0; end
                default: begin is_load = 0; is_store = 1; end
            endcase
            ls_size       = 4'b0001 << $urandom_range(0, 3);
            is_unsigned   = $urandom_range(0, 1);
            ls_address    = {$urandom, $urandom};
            store_data    = {$urandom, $urandom};
            rd            = LREG_W'($urandom_range(0, 31));
            flush         = ($urandom_range(0, 7) == 0);
            dc_req_ready  = $urandom_range(0, 1);
            dc_resp_valid = ($urandom_range(0, 2) == 0);
            dc_resp_data  = {$urandom, $urandom};
            tick();
        end
        reset = 0;
        idle_in();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit sitting downstream of the execute stage's address generator.
- Consumes a computed load/store address, size, signedness, store data and destination register.
- Issues one data-cache request over a valid/ready handshake and waits for the load response.
- Aligns and sign/zero-extends load data, then produces a one-cycle writeback pulse; single outstanding access, flushable by redirect.

Parameters:
- XLEN, 64, width of address, store data and load result.
- LREG_W, 5, width of destination register index.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  execute stage presents a memory op
- in_ready  out  1  unit can accept (state IDLE and no flush)
- is_load  in  1  op is load
- is_store  in  1  op is store
- ls_size  in  4  one-hot: [0] byte, [1] half, [2] word, [3] double
- is_unsigned  in  1  zero-extend load result
- ls_address  in  XLEN  effective byte address
- store_data  in  XLEN  store source, right-aligned
- rd  in  LREG_W  load destination register
- flush  in  1  redirect; cancel current op
- dc_req_valid  out  1  cache request valid
- dc_req_ready  in  1  cache accepts request
- dc_req_addr  out  XLEN  ls_address with bits [2:0] cleared
- dc_req_wen  out  1  1 = store
- dc_req_wdata  out  XLEN  store_data shifted left by 8*addr[2:0]
- dc_req_wmask  out  8  byte mask shifted left by addr[2:0]
- dc_resp_valid  in  1  load data returned
- dc_resp_data  in  XLEN  aligned doubleword
- wb_valid  out  1  one-cycle load writeback pulse
- wb_rd  out  LREG_W  writeback register
- wb_data  out  XLEN  extended load result
- misalign  out  1  one-cycle misaligned-access pulse

Behaviour:
- States: IDLE, REQ, WAIT, DRAIN. Reset: IDLE; all outputs 0, except in_ready = 1 once reset deasserts.
- IDLE: in_ready = !flush. Handshake = in_valid && in_ready; latch all inputs and go to REQ.
  - Handshake with neither is_load nor is_store: op accepted and dropped, stay IDLE.
  - is_load and is_store both set: not legal, behaviour undefined.
- REQ: dc_req_valid = 1; addr, wen, wdata and wmask held stable until dc_req_ready.
  - Store handshake: go IDLE, no writeback.
  - Load handshake: go WAIT.
- Wmask per size: B 0x01, H 0x03, W 0x0F, D 0xFF, shifted by addr[2:0]; bits shifted past bit 7 are dropped.
- WAIT: on dc_resp_valid, shift dc_resp_data right by 8*addr[2:0], truncate to size, extend per is_unsigned.
  - Register result: wb_valid = 1 for exactly the next cycle with wb_rd/wb_data; go IDLE.
  - wb_data and wb_rd hold their values after the pulse.
- Minimum load latency: accept at cycle N, request at N+1, response at N+2, wb_valid at N+3.
- Minimum store: accept at N, request handshake at N+1, in_ready at N+2.
- Flush handling:
  - In REQ without a handshake that cycle: request withdrawn, go IDLE.
  - In REQ with a handshake in the same cycle: a store is committed (go IDLE); a load goes to DRAIN.
  - In WAIT: go DRAIN.
  - In DRAIN: wait for dc_resp_valid, discard it, no wb_valid, go IDLE; further flushes ignored.
  - Flush in IDLE blocks acceptance that cycle.
- dc_resp_valid outside WAIT/DRAIN is ignored.
- Reset asserted mid-operation: immediate return to IDLE and output clear. The cache is reset by the same reset, so no response is drained.

Optional Feature:
- Macro LSU_MISALIGN_CHECK_EN.
- When defined, on handshake check alignment: H requires addr[0]=0, W requires addr[1:0]=0, D requires addr[2:0]=0.
  - Misaligned op: no cache request, stay IDLE, misalign = 1 for the next cycle, no wb_valid.
- When undefined: misalign tied 0, no check; lanes wrap/drop as described above.

Test Plan:
- Load D, addr 0x1000, ready=1, resp 0x1122334455667788 next cycle -> dc_req_addr 0x1000, wmask 0x00, wb_valid at N+3, wb_data 0x1122334455667788.
- Signed load B, addr 0x1003, resp 0x00000000_80FF0000 -> wb_data 0xFFFFFFFFFFFFFF80; same with is_unsigned=1 -> 0x80.
- Store H, addr 0x2006, data 0xABCD, dc_req_ready low 3 cycles -> request held stable 4 cycles: wdata 0xABCD000000000000, wmask 0xC0, wen=1; no wb_valid.
- Load W, flush during WAIT, response arrives 2 cycles later -> no wb_valid, in_ready returns the cycle after the response.
- Flush in REQ with ready=0 -> dc_req_valid drops next cycle, in_ready=1; new load then completes normally.
- With LSU_MISALIGN_CHECK_EN: load W at 0x1002 -> no dc_req_valid, misalign pulse 1 cycle; without the macro -> request addr 0x1000, wb_data = bytes 2..5 of the response.
